// File: rtl/mini_core_pv_pkg.sv
// mini_core_pv shared package: opcodes, instruction layout helpers.
// Optional MUL opcode is enabled by defining MINI_CORE_MUL_EN.
package mini_core_pkg;

  localparam int OPC_W = 4;
  localparam int REG_AW_DEF = 8;
  localparam int INSTR_W_DEF = OPC_W + 3 * REG_AW_DEF;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LED = 4'd1;
  localparam logic [3:0] OP_BLE = 4'd2;
  localparam logic [3:0] OP_STO = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_VGA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;

  function automatic int instr_w(input int aw);
    return OPC_W + 3 * aw;
  endfunction

  function automatic int op_lsb(input int aw);
    return 3 * aw;
  endfunction

  function automatic int dst_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int src1_lsb(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/mini_core_pv_if.sv
// mini_core_pv video write port: valid/ready request with
// linear pixel address and colour.
interface mini_core_pv_if #(
  parameter int VADDR_W = 14,
  parameter int COLOR_W = 3
);
  logic               oVgaValid;
  logic               iVgaReady;
  logic [VADDR_W-1:0] oVgaAddr;
  logic [COLOR_W-1:0] oVgaColor;

  modport master (
    output oVgaValid,
    output oVgaAddr,
    output oVgaColor,
    input  iVgaReady
  );

  modport slave (
    input  oVgaValid,
    input  oVgaAddr,
    input  oVgaColor,
    output iVgaReady
  );
endinterface

// File: rtl/mini_core_pv_regfile.sv
// mini_core_pv register file: 2 async reads, 1 sync write,
// synchronous clear.
module mini_core_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ra0_i,
  input  logic [REG_AW-1:0] ra1_i,
  output logic [DATA_W-1:0] rd0_o,
  output logic [DATA_W-1:0] rd1_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [NREG];

  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/mini_core_pv.sv
// mini_core_pv: 2-stage fetch/execute core with LED latch and
// video write port. Define MINI_CORE_MUL_EN to enable opcode 8 (MUL).
module mini_core_pv
  import mini_core_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 8,
  parameter int IP_W    = 16,
  parameter int LED_W   = 8,
  parameter int COLOR_W = 3,
  parameter int H_RES   = 100,
  parameter int V_RES   = 100,
  parameter int VADDR_W = 14,
  localparam int IW     = OPC_W + 3 * REG_AW
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic [IP_W-1:0]  oIP,
  input  logic [IW-1:0]    iInstruction,
  mini_core_pv_if.master   vga,
  output logic [LED_W-1:0] oLed,
  output logic             oIllegal,
  output logic             oFault
);
  localparam int OP_L = op_lsb(REG_AW);
  localparam int DS_L = dst_lsb(REG_AW);
  localparam int S1_L = src1_lsb(REG_AW);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0]  H_LIM = DATA_W'(H_RES);
  localparam logic [DATA_W-1:0]  V_LIM = DATA_W'(V_RES);
  localparam logic [VADDR_W-1:0] H_MUL = VADDR_W'(H_RES);

  logic [IW-1:0]      ir_q, ir_d;
  logic [IP_W-1:0]    pc_q, pc_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               vld_q, vld_d;
  logic [VADDR_W-1:0] vadr_q, vadr_d;
  logic [COLOR_W-1:0] vcol_q, vcol_d;
  logic               flt_q, flt_d;
  logic               ill_q, ill_d;

  logic [3:0]        op;
  logic [REG_AW-1:0] dst, src1, src0;
  logic [DATA_W-1:0] rd0, rd1, wd;
  logic              we, taken, vga_op, stall, in_rng;

  assign op   = ir_q[OP_L +: OPC_W];
  assign dst  = ir_q[DS_L +: REG_AW];
  assign src1 = ir_q[S1_L +: REG_AW];
  assign src0 = ir_q[0 +: REG_AW];

  mini_core_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_rf (
    .clk_i (Clock),
    .rst_i (Reset),
    .ra0_i (src0),
    .ra1_i (src1),
    .rd0_o (rd0),
    .rd1_o (rd1),
    .we_i  (we),
    .wa_i  (dst),
    .wd_i  (wd)
  );

  always_comb begin
    we     = 1'b0;
    wd     = '0;
    taken  = 1'b0;
    vga_op = 1'b0;
    ill_d  = 1'b0;
    led_d  = led_q;
    unique case (1'b1)
      op == OP_NOP: ;
      op == OP_LED: led_d = rd1[LED_W-1:0];
      op == OP_BLE: taken = (rd1 <= rd0);
      op == OP_STO: begin
        we = 1'b1;
        wd = DATA_W'({src1, src0});
      end
      op == OP_ADD: begin
        we = 1'b1;
        wd = rd1 + rd0;
      end
      op == OP_JMP: taken = 1'b1;
      op == OP_SUB: begin
        we = 1'b1;
        wd = rd1 - rd0;
      end
      op == OP_VGA: vga_op = 1'b1;
`ifdef MINI_CORE_MUL_EN
      op == OP_MUL: begin
        we = 1'b1;
        wd = rd1 * rd0;
      end
`endif
      op == OP_SHL: begin
        we = 1'b1;
        wd = rd1 << rd0[SH_W-1:0];
      end
      default: ill_d = 1'b1;
    endcase
  end

  // A new request may load in the same cycle the pending one is accepted
  assign stall  = vga_op && vld_q && !vga.iVgaReady;
  assign in_rng = (rd0 < H_LIM) && (rd1 < V_LIM);

  always_comb begin
    oIP    = taken ? IP_W'(dst) : pc_q;
    ir_d   = stall ? ir_q : iInstruction;
    pc_d   = stall ? pc_q : oIP + IP_W'(1);
    vld_d  = vld_q && !vga.iVgaReady;
    vadr_d = vadr_q;
    vcol_d = vcol_q;
    flt_d  = flt_q;
    if (vga_op && !stall) begin
      if (in_rng) begin
        vld_d  = 1'b1;
        vadr_d = VADDR_W'(rd1) * H_MUL + VADDR_W'(rd0);
        vcol_d = dst[COLOR_W-1:0];
      end else begin
        flt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_q   <= '0;
      pc_q   <= '0;
      led_q  <= '0;
      vld_q  <= 1'b0;
      vadr_q <= '0;
      vcol_q <= '0;
      flt_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      pc_q   <= pc_d;
      led_q  <= led_d;
      vld_q  <= vld_d;
      vadr_q <= vadr_d;
      vcol_q <= vcol_d;
      flt_q  <= flt_d;
      ill_q  <= ill_d;
    end
  end

  assign oLed          = led_q;
  assign oIllegal      = ill_q;
  assign oFault        = flt_q;
  assign vga.oVgaValid = vld_q;
  assign vga.oVgaAddr  = vadr_q;
  assign vga.oVgaColor = vcol_q;
endmodule

// File: tb/tb_mini_core_pv.sv
// Directed-vector bench for mini_core_pv with a combinational ROM.
// Expectations for opcode 8 follow MINI_CORE_MUL_EN.
module tb_mini_core_pv;
  logic        Clock;
  logic        Reset;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [7:0]  oLed;
  logic        oIllegal;
  logic        oFault;
  logic [27:0] rom [256];
  int          n_chk;
  int          n_err;

  mini_core_pv_if #(.VADDR_W(14), .COLOR_W(3)) vif ();

  mini_core_pv dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .vga          (vif),
    .oLed         (oLed),
    .oIllegal     (oIllegal),
    .oFault       (oFault)
  );

  assign iInstruction = rom[oIP[7:0]];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [27:0] ins(
    input logic [3:0] op,
    input logic [7:0] d,
    input logic [7:0] s1,
    input logic [7:0] s0
  );
    return {op, d, s1, s0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge Clock);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    Reset = 1'b0;
    vif.iVgaReady = 1'b0;
    rom_clear();

    // arithmetic and LED
    rom[0] = ins(4'd3, 8'd1, 8'd0, 8'd5);
    rom[1] = ins(4'd3, 8'd2, 8'd0, 8'd7);
    rom[2] = ins(4'd4, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    step(1);
    do_reset();
    chk("rst_ip", 32'(oIP), 32'd0);
    chk("rst_led", 32'(oLed), 32'd0);
    chk("rst_vld", 32'(vif.oVgaValid), 32'd0);
    chk("rst_adr", 32'(vif.oVgaAddr), 32'd0);
    chk("rst_col", 32'(vif.oVgaColor), 32'd0);
    chk("rst_ill", 32'(oIllegal), 32'd0);
    chk("rst_flt", 32'(oFault), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      step(1);
      chk("seq_ip", 32'(oIP), 32'(c));
    end
    chk("led_pre", 32'(oLed), 32'd0);
    step(1);
    chk("led_add", 32'(oLed), 32'd12);

    // taken BLE, fall-through slot must not execute
    rom_clear();
    rom[0]    = ins(4'd3, 8'd1, 8'd0, 8'd3);
    rom[1]    = ins(4'd3, 8'd2, 8'd0, 8'd3);
    rom[2]    = ins(4'd2, 8'h20, 8'd1, 8'd2);
    rom[3]    = ins(4'd1, 8'd0, 8'd1, 8'd0);
    rom[8'h20] = ins(4'd3, 8'd5, 8'd0, 8'd9);
    rom[8'h21] = ins(4'd1, 8'd0, 8'd5, 8'd0);
    do_reset();
    step(3);
    chk("ble_ip", 32'(oIP), 32'h20);
    step(1);
    chk("ble_nxt", 32'(oIP), 32'h21);
    step(1);
    chk("ble_sq", 32'(oLed), 32'd0);
    step(1);
    chk("ble_led", 32'(oLed), 32'd9);

    // VGA request held, second VGA stalls, back-to-back on accept
    rom_clear();
    rom[0] = ins(4'd3, 8'd1, 8'd0, 8'd99);
    rom[1] = ins(4'd7, 8'd5, 8'd1, 8'd1);
    rom[2] = ins(4'd7, 8'd2, 8'd0, 8'd0);
    vif.iVgaReady = 1'b0;
    do_reset();
    step(2);
    chk("vga_ip2", 32'(oIP), 32'd2);
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("vga_vld", 32'(vif.oVgaValid), 32'd1);
      chk("vga_adr", 32'(vif.oVgaAddr), 32'd9999);
      chk("vga_col", 32'(vif.oVgaColor), 32'd5);
      chk("vga_stl", 32'(oIP), 32'd3);
    end
    vif.iVgaReady = 1'b1;
    step(1);
    chk("b2b_vld", 32'(vif.oVgaValid), 32'd1);
    chk("b2b_adr", 32'(vif.oVgaAddr), 32'd0);
    chk("b2b_col", 32'(vif.oVgaColor), 32'd2);
    chk("b2b_ip", 32'(oIP), 32'd4);
    step(1);
    chk("acc_vld", 32'(vif.oVgaValid), 32'd0);
    vif.iVgaReady = 1'b0;

    // out-of-range pixel
    rom_clear();
    rom[0] = ins(4'd3, 8'd1, 8'd0, 8'd100);
    rom[1] = ins(4'd7, 8'd1, 8'd0, 8'd1);
    do_reset();
    step(3);
    chk("oob_vld", 32'(vif.oVgaValid), 32'd0);
    chk("oob_flt", 32'(oFault), 32'd1);
    step(3);
    chk("flt_hold", 32'(oFault), 32'd1);
    do_reset();
    chk("flt_rst", 32'(oFault), 32'd0);

    // opcode 8 and an always-illegal opcode
    rom_clear();
    rom[0] = ins(4'd3, 8'd1, 8'h03, 8'h00);
    rom[1] = ins(4'd3, 8'd2, 8'h01, 8'h01);
    rom[2] = ins(4'd3, 8'd3, 8'h00, 8'h77);
    rom[3] = ins(4'd8, 8'd3, 8'd1, 8'd2);
    rom[4] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    rom[5] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    do_reset();
    step(5);
`ifdef MINI_CORE_MUL_EN
    chk("mul_ill", 32'(oIllegal), 32'd0);
    step(1);
    chk("mul_led", 32'(oLed), 32'h00);
`else
    chk("mul_ill", 32'(oIllegal), 32'd1);
    step(1);
    chk("mul_led", 32'(oLed), 32'h77);
`endif
    chk("ill_pls", 32'(oIllegal), 32'd0);
    step(1);
    chk("op15_ill", 32'(oIllegal), 32'd1);

    // SUB wrap, then reset during a pending request
    rom_clear();
    rom[0]    = ins(4'd3, 8'd1, 8'd0, 8'd1);
    rom[1]    = ins(4'd6, 8'd2, 8'd0, 8'd1);
    rom[2]    = ins(4'd1, 8'd0, 8'd2, 8'd0);
    rom[3]    = ins(4'd3, 8'd3, 8'hFF, 8'hFF);
    rom[4]    = ins(4'd2, 8'h40, 8'd3, 8'd2);
    rom[8'h40] = ins(4'd7, 8'd1, 8'd0, 8'd0);
    vif.iVgaReady = 1'b0;
    do_reset();
    step(4);
    chk("sub_led", 32'(oLed), 32'hFF);
    step(1);
    chk("sub_ble", 32'(oIP), 32'h40);
    step(2);
    chk("pend_vld", 32'(vif.oVgaValid), 32'd1);
    rom_clear();
    rom[0] = ins(4'd2, 8'h10, 8'd2, 8'd0);
    do_reset();
    chk("rst_drop", 32'(vif.oVgaValid), 32'd0);
    chk("rst_led2", 32'(oLed), 32'd0);
    step(1);
    chk("rst_regs", 32'(oIP), 32'h10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
